// File: rtl/piece_supply_ctrl_pkg.sv
// rtl/piece_supply_ctrl_pkg.sv - shared types, constants and bag helper for the piece supply
package piece_supply_ctrl_pkg;

  typedef logic [2:0] piece_idx_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SPAWN,
    HOLD,
    WAIT_BAG,
    LOAD
  } supply_state_t;

  localparam piece_idx_t TETROMINO_EMPTY = 3'b111;
  localparam piece_idx_t BAG_LAST        = 3'd6;

  // Inside-out Fisher-Yates pick: uniform-ish j in 0..i from the low LFSR byte.
  function automatic piece_idx_t bag_pick(input logic [7:0] r, input piece_idx_t i);
    case (i)
      3'd1:    return piece_idx_t'(r % 8'd2);
      3'd2:    return piece_idx_t'(r % 8'd3);
      3'd3:    return piece_idx_t'(r % 8'd4);
      3'd4:    return piece_idx_t'(r % 8'd5);
      3'd5:    return piece_idx_t'(r % 8'd6);
      3'd6:    return piece_idx_t'(r % 8'd7);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tetromino_bag7.sv
// rtl/tetromino_bag7.sv - 7-bag randomiser: Galois LFSR driving a 7-cycle shuffle refill
module tetromino_bag7
  import piece_supply_ctrl_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pop,
  output piece_idx_t head,
  output logic       valid
);

  logic [15:0] lfsr;
  piece_idx_t  ram [0:6];
  piece_idx_t  rd_ptr;
  piece_idx_t  fill_i;
  piece_idx_t  pick;

  assign pick  = bag_pick(lfsr[7:0], fill_i);
  assign valid = (rd_ptr != TETROMINO_EMPTY);
  assign head  = valid ? ram[rd_ptr] : TETROMINO_EMPTY;

  // rd_ptr == 7 means empty; the refill writes one shuffle step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      rd_ptr <= TETROMINO_EMPTY;
      fill_i <= 3'd0;
      for (int k = 0; k < 7; k++) ram[k] <= 3'd0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (!valid) begin
        ram[fill_i] <= ram[pick];
        ram[pick]   <= fill_i;
        if (fill_i == BAG_LAST) begin
          fill_i <= 3'd0;
          rd_ptr <= 3'd0;
        end else begin
          fill_i <= fill_i + 3'd1;
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
    end
  end

endmodule

// File: rtl/piece_supply_ctrl.sv
// rtl/piece_supply_ctrl.sv - next/hold slots, spawn/hold arbitration and load sequencing
module piece_supply_ctrl
  import piece_supply_ctrl_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic       spawn_req,
  input  logic       hold_req,
  input  logic [2:0] curr_idx,
  output logic       piece_load,
  output logic [2:0] piece_idx,
  output logic [2:0] next_idx,
  output logic [2:0] hold_idx,
  output logic       hold_used,
  output logic       hold_denied,
  output logic       busy
);

  supply_state_t state;
  logic          pending;
  logic          wait_hold;
  piece_idx_t    bag_head;
  logic          bag_valid;
  logic          bag_pop;
  logic          act_spawn;
  logic          act_hold;
  logic          needs_bag;
  logic          stall;

  tetromino_bag7 #(.LFSR_SEED(LFSR_SEED)) u_bag (
    .clk   (clk),
    .rst_n (rst_n),
    .pop   (bag_pop),
    .head  (bag_head),
    .valid (bag_valid)
  );

  // WAIT_BAG resumes whichever action stalled, remembered in wait_hold.
  always_comb begin
    act_spawn = (state == SPAWN) || ((state == WAIT_BAG) && !wait_hold);
    act_hold  = (state == HOLD)  || ((state == WAIT_BAG) &&  wait_hold);
    needs_bag = act_spawn || (act_hold && (hold_idx == TETROMINO_EMPTY));
    stall     = needs_bag && !bag_valid;
    bag_pop   = bag_valid && ((state == INIT) || needs_bag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      pending     <= 1'b0;
      wait_hold   <= 1'b0;
      piece_load  <= 1'b0;
      piece_idx   <= 3'd0;
      next_idx    <= TETROMINO_EMPTY;
      hold_idx    <= TETROMINO_EMPTY;
      hold_used   <= 1'b0;
      hold_denied <= 1'b0;
      busy        <= 1'b1;
    end else begin
      piece_load  <= 1'b0;
      hold_denied <= 1'b0;
      case (state)
        INIT: begin
          if (bag_valid) begin
            next_idx <= bag_head;
            state    <= SPAWN;
          end
        end
        IDLE: begin
          if (game_active && (spawn_req || pending)) begin
            state       <= SPAWN;
            busy        <= 1'b1;
            pending     <= 1'b0;
            hold_denied <= hold_req;
          end else if (game_active && hold_req) begin
            if (hold_used) begin
              hold_denied <= 1'b1;
            end else begin
              state <= HOLD;
              busy  <= 1'b1;
            end
          end
        end
        SPAWN, HOLD, WAIT_BAG: begin
          if (stall) begin
            state     <= WAIT_BAG;
            wait_hold <= act_hold;
          end else begin
            if (act_spawn) begin
              piece_idx <= next_idx;
              next_idx  <= bag_head;
              hold_used <= 1'b0;
            end else if (hold_idx == TETROMINO_EMPTY) begin
              hold_idx  <= curr_idx;
              piece_idx <= next_idx;
              next_idx  <= bag_head;
              hold_used <= 1'b1;
            end else begin
              piece_idx <= hold_idx;
              hold_idx  <= curr_idx;
              hold_used <= 1'b1;
            end
            piece_load <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= INIT;
      endcase
      if ((state != IDLE) && game_active) begin
        if (spawn_req) pending <= 1'b1;
        if (hold_req) hold_denied <= 1'b1;
      end
    end
  end

endmodule
